// File: rtl/tsu_pkg.sv
// Shared definitions for the timestamp unit: the tracker state encoding,
// the default frame layout offsets, the critical EtherType and the timestamp width.
package tsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_TS   = 2'd2,
    ST_TAIL = 2'd3
  } tsu_state_e;

  localparam logic [15:0] TSU_CRIT_ETHERTYPE = 16'h88B5;
  localparam int          TSU_TX_TS_OFS      = 20;
  localparam int          TSU_RX_TS_OFS      = 28;
  localparam int          TSU_TS_W           = 64;
  localparam int          TSU_IDX_W          = 6;

  function automatic logic [TSU_IDX_W-1:0] tsu_idx(input int ofs);
    return TSU_IDX_W'(ofs);
  endfunction

endpackage

// File: rtl/axis_ethertype_checker.sv
// Flags the current frame as critical once bytes 12-13 (EtherType, MSB first)
// match CRIT_ETHERTYPE; the flag clears on the tlast beat.
module axis_ethertype_checker
  import tsu_pkg::*;
#(
  parameter logic [15:0] CRIT_ETHERTYPE = TSU_CRIT_ETHERTYPE
) (
  input  logic                 mac_axis_aclk,
  input  logic                 rst,
  input  logic                 beat,
  input  logic [TSU_IDX_W-1:0] byte_idx,
  input  logic [7:0]           tdata,
  input  logic                 tlast,
  output logic                 crit
);

  logic [7:0] etype_hi;

  always_ff @(posedge mac_axis_aclk or posedge rst) begin
    if (rst) begin
      etype_hi <= 8'h00;
      crit     <= 1'b0;
    end else if (beat) begin
      if (tlast) begin
        crit <= 1'b0;
      end else if (byte_idx == tsu_idx(12)) begin
        etype_hi <= tdata;
      end else if (byte_idx == tsu_idx(13)) begin
        crit <= ({etype_hi, tdata} == CRIT_ETHERTYPE);
      end
    end
  end

endmodule

// File: rtl/tsu_latency_extractor.sv
// Passive AXI-Stream monitor: extracts departure/arrival timestamps from critical
// frames and emits rx_ts - tx_ts. Statistics are built only with TSU_LAT_STATS_EN.
module tsu_latency_extractor
  import tsu_pkg::*;
#(
  parameter logic [15:0] CRIT_ETHERTYPE = TSU_CRIT_ETHERTYPE,
  parameter int          TX_TS_OFS      = TSU_TX_TS_OFS,
  parameter int          RX_TS_OFS      = TSU_RX_TS_OFS
) (
  input  logic                mac_axis_aclk,
  input  logic                rst,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tready,
  input  logic [7:0]          s_axis_tdata,
  input  logic                s_axis_tlast,
  output logic                lat_valid,
  input  logic                lat_ready,
  output logic [TSU_TS_W-1:0] lat_value,
  output logic                lat_neg,
  output logic [15:0]         lat_drop_cnt,
  input  logic                stat_clr,
  output logic [31:0]         stat_cnt,
  output logic [TSU_TS_W-1:0] stat_min,
  output logic [TSU_TS_W-1:0] stat_max,
  output tsu_state_e          state_dbg
);

  localparam logic [TSU_IDX_W-1:0] TX_FIRST = tsu_idx(TX_TS_OFS);
  localparam logic [TSU_IDX_W-1:0] TX_LAST  = tsu_idx(TX_TS_OFS + 7);
  localparam logic [TSU_IDX_W-1:0] RX_FIRST = tsu_idx(RX_TS_OFS);
  localparam logic [TSU_IDX_W-1:0] RX_LAST  = tsu_idx(RX_TS_OFS + 7);
  localparam logic [TSU_IDX_W-1:0] MIN_LAST = tsu_idx(RX_TS_OFS + 8);

  logic                 beat;
  logic [TSU_IDX_W-1:0] byte_idx;
  tsu_state_e           state, state_n;
  logic [TSU_TS_W-1:0]  tx_ts, rx_ts;
  logic                 crit;
  logic                 rec_load, rec_accept, rec_neg;
  logic [TSU_TS_W-1:0]  rec_value;

  assign beat      = s_axis_tvalid & s_axis_tready;
  assign state_dbg = state;

  always_ff @(posedge mac_axis_aclk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      state    <= ST_IDLE;
    end else begin
      state <= state_n;
      if (beat) begin
        if (s_axis_tlast)       byte_idx <= '0;
        else if (byte_idx != '1) byte_idx <= byte_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    if (beat) begin
      if (s_axis_tlast) begin
        state_n = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state_n = ST_HDR;
          ST_HDR:  if (byte_idx == TX_FIRST) state_n = ST_TS;
          ST_TS:   if (byte_idx == RX_LAST) state_n = ST_TAIL;
          default: state_n = state;
        endcase
      end
    end
  end

  // Eight shifts fully overwrite each timestamp, so a short frame leaves no residue.
  always_ff @(posedge mac_axis_aclk or posedge rst) begin
    if (rst) begin
      tx_ts <= '0;
      rx_ts <= '0;
    end else if (beat) begin
      if (byte_idx >= TX_FIRST && byte_idx <= TX_LAST) tx_ts <= {tx_ts[TSU_TS_W-9:0], s_axis_tdata};
      if (byte_idx >= RX_FIRST && byte_idx <= RX_LAST) rx_ts <= {rx_ts[TSU_TS_W-9:0], s_axis_tdata};
    end
  end

  axis_ethertype_checker #(
    .CRIT_ETHERTYPE(CRIT_ETHERTYPE)
  ) u_etype (
    .mac_axis_aclk(mac_axis_aclk),
    .rst          (rst),
    .beat         (beat),
    .byte_idx     (byte_idx),
    .tdata        (s_axis_tdata),
    .tlast        (s_axis_tlast),
    .crit         (crit)
  );

  assign rec_load   = beat & s_axis_tlast & crit & (byte_idx >= MIN_LAST);
  assign rec_value  = rx_ts - tx_ts;
  assign rec_neg    = (rx_ts < tx_ts);
  assign rec_accept = rec_load & (~lat_valid | lat_ready);

  // Record handshake: lat_value/lat_neg are held while lat_valid=1 and lat_ready=0;
  // a record transfers in any cycle with lat_valid=1 and lat_ready=1.
  always_ff @(posedge mac_axis_aclk or posedge rst) begin
    if (rst) begin
      lat_valid    <= 1'b0;
      lat_value    <= '0;
      lat_neg      <= 1'b0;
      lat_drop_cnt <= '0;
    end else if (rec_accept) begin
      lat_valid <= 1'b1;
      lat_value <= rec_value;
      lat_neg   <= rec_neg;
    end else begin
      if (rec_load && lat_drop_cnt != 16'hFFFF) lat_drop_cnt <= lat_drop_cnt + 16'd1;
      if (lat_valid && lat_ready) lat_valid <= 1'b0;
    end
  end

`ifdef TSU_LAT_STATS_EN
  always_ff @(posedge mac_axis_aclk or posedge rst) begin
    if (rst) begin
      stat_cnt <= '0;
      stat_min <= '1;
      stat_max <= '0;
    end else if (stat_clr) begin
      stat_cnt <= '0;
      stat_min <= '1;
      stat_max <= '0;
    end else if (rec_accept) begin
      if (stat_cnt != '1) stat_cnt <= stat_cnt + 32'd1;
      if (!rec_neg) begin
        if (rec_value < stat_min) stat_min <= rec_value;
        if (rec_value > stat_max) stat_max <= rec_value;
      end
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_cnt = '0;
  assign stat_min = '0;
  assign stat_max = '0;
`endif

endmodule

// File: tb/tb_tsu_latency_extractor.sv
// Directed bench for tsu_latency_extractor: a table of frames with hand-computed
// latencies, then sequences for holding/dropping, stat_clr and mid-frame reset.
module tb_tsu_latency_extractor;
  import tsu_pkg::*;

  logic        mac_axis_aclk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  s_axis_tdata;
  logic        lat_valid, lat_ready, lat_neg, stat_clr;
  logic [63:0] lat_value, stat_min, stat_max;
  logic [15:0] lat_drop_cnt;
  logic [31:0] stat_cnt;
  tsu_state_e  state_dbg;

  always #5 mac_axis_aclk = ~mac_axis_aclk;

  tsu_latency_extractor dut (
    .mac_axis_aclk(mac_axis_aclk),
    .rst          (rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .lat_valid    (lat_valid),
    .lat_ready    (lat_ready),
    .lat_value    (lat_value),
    .lat_neg      (lat_neg),
    .lat_drop_cnt (lat_drop_cnt),
    .stat_clr     (stat_clr),
    .stat_cnt     (stat_cnt),
    .stat_min     (stat_min),
    .stat_max     (stat_max),
    .state_dbg    (state_dbg)
  );

  typedef struct {
    logic [15:0] etype;
    logic [63:0] tx;
    logic [63:0] rx;
    int          len;
    bit          gaps;
    bit          exp_valid;
    logic [63:0] exp_val;
    bit          exp_neg;
  } vec_t;

  vec_t        vecs[10];
  logic [7:0]  frame_buf[64];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] e_cnt;
  logic [63:0] e_min, e_max;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
`ifdef TSU_LAT_STATS_EN
    e_cnt = 0; e_min = '1; e_max = 0;
`else
    e_cnt = 0; e_min = 0; e_max = 0;
`endif
  endtask

  task automatic model_load(input logic [63:0] v, input bit neg);
`ifdef TSU_LAT_STATS_EN
    e_cnt = e_cnt + 1;
    if (!neg) begin
      if (v < e_min) e_min = v;
      if (v > e_max) e_max = v;
    end
`else
    if (neg && v == 0) e_cnt = 0;
`endif
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, " stat_cnt"}, {32'd0, stat_cnt}, {32'd0, e_cnt});
    chk({tag, " stat_min"}, stat_min, e_min);
    chk({tag, " stat_max"}, stat_max, e_max);
  endtask

  task automatic build_frame(input logic [15:0] etype, input logic [63:0] tx, input logic [63:0] rx);
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'(i * 7 + 3);
    frame_buf[12] = etype[15:8];
    frame_buf[13] = etype[7:0];
    for (int k = 0; k < 8; k++) begin
      frame_buf[TSU_TX_TS_OFS + k] = tx[63 - 8*k -: 8];
      frame_buf[TSU_RX_TS_OFS + k] = rx[63 - 8*k -: 8];
    end
  endtask

  // Leaves the tlast byte on the bus; caller follows with idle() or another frame.
  task automatic send_frame(input int len, input bit gaps, input bit rdy_last);
    for (int i = 0; i < len; i++) begin
      if (gaps && (i == 5 || i == 22)) begin
        @(negedge mac_axis_aclk);
        s_axis_tvalid = 1'b1; s_axis_tready = 1'b0; s_axis_tdata = 8'hFF; s_axis_tlast = 1'b1;
        @(negedge mac_axis_aclk);
        s_axis_tvalid = 1'b0; s_axis_tready = 1'b1; s_axis_tdata = 8'hEE; s_axis_tlast = 1'b1;
      end
      @(negedge mac_axis_aclk);
      s_axis_tvalid = 1'b1;
      s_axis_tready = 1'b1;
      s_axis_tdata  = frame_buf[i];
      s_axis_tlast  = (i == len - 1);
      if (rdy_last && i == len - 1) lat_ready = 1'b1;
    end
  endtask

  task automatic idle();
    @(negedge mac_axis_aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (2) @(negedge mac_axis_aclk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " lat_valid"}, {63'd0, lat_valid}, 64'd0);
    chk({tag, " lat_value"}, lat_value, 64'd0);
    chk({tag, " lat_neg"}, {63'd0, lat_neg}, 64'd0);
    chk({tag, " drop_cnt"}, {48'd0, lat_drop_cnt}, 64'd0);
    chk({tag, " state"}, {62'd0, state_dbg}, {62'd0, ST_IDLE});
    chk_stats(tag);
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tready = 1'b1; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0;
    lat_ready = 1'b1; stat_clr = 1'b0;
    model_reset();

    vecs[0] = '{16'h88B5, 64'h100, 64'h1F4, 64, 0, 1, 64'hF4, 0};
    vecs[1] = '{16'h0800, 64'h100, 64'h1F4, 64, 0, 0, 64'h0, 0};
    vecs[2] = '{16'h88B5, 64'h200, 64'h100, 64, 0, 1, 64'hFFFF_FFFF_FFFF_FF00, 1};
    vecs[3] = '{16'h88B5, 64'h3E8, 64'h5DC, 37, 1, 1, 64'h1F4, 0};
    vecs[4] = '{16'h88B5, 64'h100, 64'h1F4, 36, 0, 0, 64'h0, 0};
    vecs[5] = '{16'h88B5, 64'h100, 64'h1F4, 31, 0, 0, 64'h0, 0};
    vecs[6] = '{16'h88B5, 64'h10, 64'h20, 40, 0, 1, 64'h10, 0};
    vecs[7] = '{16'h88B4, 64'h100, 64'h1F4, 64, 0, 0, 64'h0, 0};
    vecs[8] = '{16'h88B5, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0005, 64, 1, 1, 64'h1_0000_0005, 0};
    vecs[9] = '{16'h88B5, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 48, 0, 1, 64'h0, 0};

    @(negedge mac_axis_aclk);
    chk_reset_vals("por");
    @(negedge mac_axis_aclk);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      lat_ready = 1'b1;
      build_frame(vecs[v].etype, vecs[v].tx, vecs[v].rx);
      send_frame(vecs[v].len, vecs[v].gaps, 1'b0);
      idle();
      chk($sformatf("vec%0d lat_valid", v), {63'd0, lat_valid}, {63'd0, vecs[v].exp_valid});
      if (vecs[v].exp_valid) begin
        chk($sformatf("vec%0d lat_value", v), lat_value, vecs[v].exp_val);
        chk($sformatf("vec%0d lat_neg", v), {63'd0, lat_neg}, {63'd0, vecs[v].exp_neg});
        model_load(vecs[v].exp_val, vecs[v].exp_neg);
      end
      chk_stats($sformatf("vec%0d", v));
      @(negedge mac_axis_aclk);
      chk($sformatf("vec%0d cleared", v), {63'd0, lat_valid}, 64'd0);
      chk($sformatf("vec%0d state", v), {62'd0, state_dbg}, {62'd0, ST_IDLE});
    end

    // Two back-to-back records with the consumer stalled: second is dropped.
    do_reset();
    lat_ready = 1'b0;
    build_frame(16'h88B5, 64'h100, 64'h1F4);
    send_frame(64, 0, 0);
    build_frame(16'h88B5, 64'h1000, 64'h1003);
    send_frame(64, 0, 0);
    idle();
    model_load(64'hF4, 0);
    chk("hold lat_valid", {63'd0, lat_valid}, 64'd1);
    chk("hold lat_value", lat_value, 64'hF4);
    chk("hold drop_cnt", {48'd0, lat_drop_cnt}, 64'd1);
    repeat (3) @(negedge mac_axis_aclk);
    chk("hold stable value", lat_value, 64'hF4);
    chk("hold stable valid", {63'd0, lat_valid}, 64'd1);
    chk_stats("hold");
    lat_ready = 1'b1;
    @(negedge mac_axis_aclk);
    chk("hold released", {63'd0, lat_valid}, 64'd0);

    // Same pair, but the consumer accepts in the cycle of the second tlast.
    do_reset();
    lat_ready = 1'b0;
    build_frame(16'h88B5, 64'h100, 64'h1F4);
    send_frame(64, 0, 0);
    build_frame(16'h88B5, 64'h1000, 64'h1003);
    send_frame(64, 0, 1);
    idle();
    model_load(64'hF4, 0);
    model_load(64'h3, 0);
    chk("reload lat_valid", {63'd0, lat_valid}, 64'd1);
    chk("reload lat_value", lat_value, 64'h3);
    chk("reload drop_cnt", {48'd0, lat_drop_cnt}, 64'd0);
    chk_stats("reload");
    @(negedge mac_axis_aclk);
    chk("reload released", {63'd0, lat_valid}, 64'd0);

    // stat_clr coinciding with a record load.
    lat_ready = 1'b1;
    build_frame(16'h88B5, 64'h0, 64'h50);
    send_frame(40, 0, 0);
    stat_clr = 1'b1;
    idle();
    stat_clr = 1'b0;
`ifdef TSU_LAT_STATS_EN
    model_reset();
`endif
    chk("clr lat_valid", {63'd0, lat_valid}, 64'd1);
    chk("clr lat_value", lat_value, 64'h50);
    chk_stats("clr");
    build_frame(16'h88B5, 64'h7, 64'h70);
    send_frame(40, 0, 0);
    idle();
    model_load(64'h69, 0);
    chk("post clr value", lat_value, 64'h69);
    chk_stats("post clr");

    // Reset pulsed at byte 25 of a critical frame, with a record pending.
    lat_ready = 1'b0;
    build_frame(16'h88B5, 64'h100, 64'h1F4);
    send_frame(64, 0, 0);
    idle();
    chk("pre-rst pending", {63'd0, lat_valid}, 64'd1);
    for (int i = 0; i < 25; i++) begin
      @(negedge mac_axis_aclk);
      s_axis_tvalid = 1'b1; s_axis_tready = 1'b1; s_axis_tdata = frame_buf[i]; s_axis_tlast = 1'b0;
    end
    @(negedge mac_axis_aclk);
    chk("mid-frame state", {62'd0, state_dbg}, {62'd0, ST_TS});
    s_axis_tdata = frame_buf[25];
    rst = 1'b1;
    model_reset();
    #1;
    chk_reset_vals("rst");
    @(negedge mac_axis_aclk);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge mac_axis_aclk);
    chk_reset_vals("post rst");
    lat_ready = 1'b1;
    build_frame(16'h88B5, 64'h10, 64'h30);
    send_frame(50, 0, 0);
    idle();
    model_load(64'h20, 0);
    chk("after rst lat_valid", {63'd0, lat_valid}, 64'd1);
    chk("after rst lat_value", lat_value, 64'h20);
    chk("after rst lat_neg", {63'd0, lat_neg}, 64'd0);
    chk_stats("after rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
